// File: rtl/xgriscv_muldiv_div_if.sv
// Request/response bundle between the EX-stage controller and the iterative divider.
// The controller is the master: it drives the request and watches busy/done/result.
interface xgriscv_muldiv_div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/xgriscv_muldiv_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operates on operand magnitudes and fixes up the signs when it enters DONE.
module xgriscv_muldiv_div #(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  xgriscv_muldiv_div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] quo, rem, dvs, result_q;
  logic            op_rem, neg_q, neg_r;

  logic            accept, is_signed, a_neg, b_neg, div_zero, overflow, special, last_iter;
  logic [XLEN-1:0] a_mag, b_mag, special_val;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] quo_step, rem_step, quo_fix, rem_fix, res_fix;

  assign accept    = bus.start && (state != CALC);
  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.a[XLEN-1];
  assign b_neg     = is_signed & bus.b[XLEN-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;
  assign div_zero  = (bus.b == '0);
  assign overflow  = is_signed && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  assign special   = div_zero | overflow;
  assign last_iter = (cnt == CNTW'(XLEN-1));

  // Divide-by-zero and signed overflow have fixed RV32M results and skip CALC.
  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = bus.op[1] ? bus.a : '1;
    else if (overflow)
      special_val = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One restoring step; the extra subtractor bit tells whether the trial went negative.
  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    diff     = rem_sh - {1'b0, dvs};
    quo_step = {quo[XLEN-2:0], ~diff[XLEN]};
    rem_step = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_fix  = neg_q ? -quo_step : quo_step;
    rem_fix  = neg_r ? -rem_step : rem_step;
    res_fix  = op_rem ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (last_iter) state_next = DONE;
      DONE: state_next = accept ? (special ? DONE : CALC) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; result only changes on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      quo    <= a_mag;
      rem    <= '0;
      dvs    <= b_mag;
      op_rem <= bus.op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      if (special)
        result_q <= special_val;
    end else if (state == CALC) begin
      cnt <= cnt + CNTW'(1);
      quo <= quo_step;
      rem <= rem_step;
      if (last_iter)
        result_q <= res_fix;
    end
  end

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_xgriscv_muldiv_div.sv
// Directed, table-driven bench for the iterative divider, plus handshake and reset sequences.
module tb_xgriscv_muldiv_div;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs[$];

  xgriscv_muldiv_div_if #(.XLEN(32)) bus ();

  xgriscv_muldiv_div #(.XLEN(32), .CNTW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents a request for one edge, then scrambles the inputs to prove they were latched.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic waitDone(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, busy_cnt, cyc;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   33});
    vecs.push_back('{OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33});
    vecs.push_back('{OP_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          33});
    vecs.push_back('{OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   33});
    vecs.push_back('{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33});
    vecs.push_back('{OP_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   33});
    vecs.push_back('{OP_DIV,  32'hFFFFFFF9,   32'd7,          32'hFFFFFFFF,   33});
    vecs.push_back('{OP_REM,  32'hFFFFFFF9,   32'd7,          32'd0,          33});
    vecs.push_back('{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33});
    vecs.push_back('{OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   33});
    vecs.push_back('{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33});
    vecs.push_back('{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1});
    vecs.push_back('{OP_REM,  32'h12345678,   32'd0,          32'h12345678,   1});
    vecs.push_back('{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1});
    vecs.push_back('{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1});

    #1 reset = 1'b1;
    #1;
    checkOutput("reset busy",   32'(bus.busy), 32'd0);
    checkOutput("reset done",   32'(bus.done), 32'd0);
    checkOutput("reset result", bus.result,    32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(lat, busy_cnt);
      checkOutput($sformatf("vec%0d result", i),  bus.result,       vecs[i].exp);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat),         32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d busy", i),    32'(busy_cnt),    32'(vecs[i].lat - 1));
      @(negedge clk);
    end

    // start pulsed mid-calculation must be dropped, not queued
    applyStimulus(OP_DIVU, 32'hFFFFFFFF, 32'h10);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      if (cyc == 10) begin
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    checkOutput("ignore latency", 32'(cyc), 32'd33);
    checkOutput("ignore result", bus.result, 32'h0FFFFFFF);
    @(negedge clk);
    checkOutput("ignore not queued busy", 32'(bus.busy), 32'd0);
    checkOutput("ignore not queued done", 32'(bus.done), 32'd0);

    // back-to-back: new request accepted in the DONE cycle
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    waitDone(lat, busy_cnt);
    checkOutput("b2b first result", bus.result, 32'd14);
    bus.start = 1'b1;
    bus.op    = OP_REMU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("b2b done falls", 32'(bus.done), 32'd0);
    checkOutput("b2b busy rises", 32'(bus.busy), 32'd1);
    checkOutput("b2b result held", bus.result, 32'd14);
    waitDone(lat, busy_cnt);
    checkOutput("b2b second latency", 32'(lat), 32'd33);
    checkOutput("b2b second result", bus.result, 32'd2);
    @(negedge clk);

    // asynchronous reset in the middle of a division
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    checkOutput("pre-reset busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midop reset busy",   32'(bus.busy), 32'd0);
    checkOutput("midop reset done",   32'(bus.done), 32'd0);
    checkOutput("midop reset result", bus.result,    32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(OP_DIVU, 32'd9, 32'd3);
    waitDone(lat, busy_cnt);
    checkOutput("post-reset latency", 32'(lat), 32'd33);
    checkOutput("post-reset result", bus.result, 32'd3);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
